// File: rtl/mips_cpu_pkg.sv
// Shared constants and types for the MIPS core: reset/exception addresses,
// ExcCode values and the fetch-stage state encoding.
package mips_cpu_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0040;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_OV      = 5'd12;

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_next_pc_mux.sv
// Combinational next-PC priority select: exception vector, eret, jr, jump,
// branch or sequential, plus which kind of exception (if any) is taken.
module next_pc_mux
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = mips_cpu_pkg::EXC_VECTOR
) (
  input  logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic [15:0] imm,
  input  logic        jump,
  input  logic [25:0] target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        eret,
  input  logic [31:0] epc_in,
  input  logic        exc_sync,
  input  logic        int_ok,
  output logic [31:0] next_pc,
  output logic        take_sync,
  output logic        take_int
);

  logic signed [31:0] br_off;
  logic               ctrl_xfer;

  assign br_off    = {{14{imm[15]}}, imm, 2'b00};
  assign ctrl_xfer = branch | jump | jr | eret;

  // An interrupt is only accepted on a plain sequential instruction so the
  // saved EPC always names a completed instruction with a simple +4 return.
  always_comb begin
    next_pc   = pc_plus4;
    take_sync = 1'b0;
    take_int  = 1'b0;
    if (exc_sync) begin
      take_sync = 1'b1;
      next_pc   = word_align(EXC_VECTOR);
    end else if (int_ok && !ctrl_xfer) begin
      take_int = 1'b1;
      next_pc  = word_align(EXC_VECTOR);
    end else if (eret) begin
      next_pc = word_align(epc_in);
    end else if (jr) begin
      next_pc = word_align(jr_addr);
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], target, 2'b00};
    end else if (branch) begin
      next_pc = pc_plus4 + $unsigned(br_off);
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter, pending-interrupt latch and RUN/HANDLER tracking for the
// fetch stage; reports EPC/Cause captures to CP0 one cycle after selection.
module pc_fetch_unit
  import mips_cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = mips_cpu_pkg::RESET_PC,
  parameter logic [31:0] EXC_VECTOR = mips_cpu_pkg::EXC_VECTOR,
  parameter logic [4:0]  INT_CAUSE  = 5'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Branch,
  input  logic [15:0] Imm,
  input  logic        Jump,
  input  logic [25:0] Target,
  input  logic        Jr,
  input  logic [31:0] Jr_addr,
  input  logic        Eret,
  input  logic [31:0] Epc_in,
  input  logic        Status_ie,
  input  logic        Int_req,
  input  logic        Exc_sync,
  input  logic [4:0]  Exc_code,
  output logic [31:0] Pc,
  output logic [31:0] Pc_plus4,
  output logic        Exc_take,
  output logic [31:0] Exc_epc,
  output logic [4:0]  Exc_cause,
  output logic        In_handler
);

  fetch_state_t state, state_next;
  logic         pending;
  logic         int_ok;
  logic         take_sync, take_int, take_any;
  logic [31:0]  next_pc;

  assign Pc_plus4   = Pc + 32'd4;
  assign In_handler = (state == HANDLER);
  // A request arriving this cycle is honoured immediately, not a cycle late.
  assign int_ok     = (pending | Int_req) & Status_ie & (state == RUN);
  assign take_any   = (take_sync | take_int) & ~Stall;

  next_pc_mux #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_mux (
    .pc_plus4 (Pc_plus4),
    .branch   (Branch),
    .imm      (Imm),
    .jump     (Jump),
    .target   (Target),
    .jr       (Jr),
    .jr_addr  (Jr_addr),
    .eret     (Eret),
    .epc_in   (Epc_in),
    .exc_sync (Exc_sync),
    .int_ok   (int_ok),
    .next_pc  (next_pc),
    .take_sync(take_sync),
    .take_int (take_int)
  );

  always_comb begin
    state_next = state;
    if (!Stall) begin
      if (take_sync || take_int) state_next = HANDLER;
      else if (Eret)             state_next = RUN;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= RUN;
    else       state <= state_next;
  end

  // The pending latch keeps sampling through stalls so a short request is not lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Pc        <= word_align(RESET_PC);
      pending   <= 1'b0;
      Exc_take  <= 1'b0;
      Exc_epc   <= 32'd0;
      Exc_cause <= 5'd0;
    end else begin
      pending  <= (take_int && !Stall) ? 1'b0 : (pending | Int_req);
      Exc_take <= take_any;
      if (!Stall) begin
        Pc <= next_pc;
        if (take_sync || take_int) begin
          Exc_epc   <= Pc;
          Exc_cause <= take_sync ? Exc_code : INT_CAUSE;
        end
      end
    end
  end

endmodule
